// File: rtl/element_cmd_player.sv
// Element-side pulse player: reads envelope words on each accepted command, scales by ampx, tags samples.
// Optional build macro ELEMENT_SAT_EN: saturate the Q1.15 product instead of wrapping.
module element_cmd_player #(
  parameter int ENV_ADDR_WIDTH   = 12,
  parameter int ENV_DATA_WIDTH   = 16,
  parameter int AMP_WIDTH        = 16,
  parameter int FREQ_WIDTH       = 9,
  parameter int PHASE_WIDTH      = 17,
  parameter int MEM_READ_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmdstb,
  input  logic [ENV_ADDR_WIDTH-1:0]        envstart,
  input  logic [ENV_ADDR_WIDTH-1:0]        envlength,
  input  logic signed [AMP_WIDTH-1:0]      ampx,
  input  logic [FREQ_WIDTH-1:0]            freqaddr,
  input  logic [PHASE_WIDTH-1:0]           pini,
  input  logic [1:0]                       mode,
  output logic                             busy,
  output logic                             env_rden,
  output logic [ENV_ADDR_WIDTH-1:0]        env_raddr,
  input  logic signed [ENV_DATA_WIDTH-1:0] env_rdata,
  output logic                             sample_valid,
  output logic signed [AMP_WIDTH-1:0]      sample,
  output logic [FREQ_WIDTH-1:0]            sample_freqaddr,
  output logic [PHASE_WIDTH-1:0]           sample_phase,
  output logic                             sample_first,
  output logic                             sample_last,
  output logic                             overrun
);

  localparam int LAT    = MEM_READ_LATENCY;
  localparam int PROD_W = ENV_DATA_WIDTH + AMP_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ENV_ADDR_WIDTH-1:0] start;
    logic [ENV_ADDR_WIDTH-1:0] len;
    logic [AMP_WIDTH-1:0]      amp;
    logic [FREQ_WIDTH-1:0]     freq;
    logic [PHASE_WIDTH-1:0]    phase;
    logic                      loop;
  } cmd_t;

  typedef struct packed {
    logic [AMP_WIDTH-1:0]   amp;
    logic [FREQ_WIDTH-1:0]  freq;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   first;
    logic                   last;
  } tag_t;

  // Q1.15 scaling: keep the product bits just below the duplicated sign bit.
  function automatic logic signed [AMP_WIDTH-1:0] scale_sample(
    input logic signed [ENV_DATA_WIDTH-1:0] d,
    input logic signed [AMP_WIDTH-1:0]      a
  );
    logic signed [PROD_W-1:0] prod;
    prod = d * a;
`ifdef ELEMENT_SAT_EN
    if (prod[PROD_W-1] != prod[PROD_W-2])
      scale_sample = prod[PROD_W-1] ? {1'b1, {(AMP_WIDTH-1){1'b0}}}
                                    : {1'b0, {(AMP_WIDTH-1){1'b1}}};
    else
      scale_sample = AMP_WIDTH'(prod >>> (ENV_DATA_WIDTH-1));
`else
    scale_sample = AMP_WIDTH'(prod >>> (ENV_DATA_WIDTH-1));
`endif
  endfunction

  state_t                    state_q, state_d;
  logic [ENV_ADDR_WIDTH-1:0] idx_q, idx_d;
  cmd_t                      cur_q, cur_d;
  cmd_t                      pend_q, pend_d;
  logic                      pend_vld_q, pend_vld_d;
  logic                      overrun_q, overrun_d;
  cmd_t                      cmd_in;
  logic                      cmd_ok;
  logic                      last_rd;
  logic                      rd_en;

  logic [LAT-1:0]            tag_vld_q, tag_vld_d;
  tag_t                      tag_q [LAT];
  tag_t                      tag_d [LAT];
  tag_t                      tag_in;

  logic                      sample_valid_q, sample_valid_d;
  logic [AMP_WIDTH-1:0]      sample_q, sample_d;
  logic [FREQ_WIDTH-1:0]     sample_freqaddr_q, sample_freqaddr_d;
  logic [PHASE_WIDTH-1:0]    sample_phase_q, sample_phase_d;
  logic                      sample_first_q, sample_first_d;
  logic                      sample_last_q, sample_last_d;

  always_comb begin
    cmd_in.start = envstart;
    cmd_in.len   = envlength;
    cmd_in.amp   = ampx;
    cmd_in.freq  = freqaddr;
    cmd_in.phase = pini;
    cmd_in.loop  = (mode == 2'b01);
  end

  assign cmd_ok  = cmdstb && (envlength != '0);
  assign last_rd = (idx_q == cur_q.len - ENV_ADDR_WIDTH'(1));

  // Command FSM: a strobe on the last read is treated exactly like a pending command.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    rd_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_ok) begin
          state_d = RUN;
          cur_d   = cmd_in;
          idx_d   = '0;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        if (last_rd) begin
          idx_d = '0;
          if (cmd_ok) begin
            cur_d      = cmd_in;
            pend_vld_d = 1'b0;
            if (pend_vld_q) overrun_d = 1'b1;
          end else if (pend_vld_q) begin
            cur_d      = pend_q;
            pend_vld_d = 1'b0;
          end else if (!cur_q.loop) begin
            state_d = DRAIN;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (cmd_ok) begin
            pend_d     = cmd_in;
            pend_vld_d = 1'b1;
            if (pend_vld_q) overrun_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cmd_ok) begin
          state_d = RUN;
          cur_d   = cmd_in;
          idx_d   = '0;
        end else if (tag_vld_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign env_rden  = rd_en;
  assign env_raddr = rd_en ? (cur_q.start + idx_q) : '0;

  // Stage p0..pLAT-1: tags follow each read until its memory word arrives.
  always_comb begin
    tag_in.amp   = cur_q.amp;
    tag_in.freq  = cur_q.freq;
    tag_in.phase = cur_q.phase;
    tag_in.first = (idx_q == '0);
    tag_in.last  = last_rd;
    tag_vld_d    = '0;
    tag_vld_d[0] = rd_en;
    tag_d[0]     = tag_in;
    for (int k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_d[k]     = tag_q[k-1];
    end
  end

  // Output stage: scale the arriving word and register it with its tags.
  always_comb begin
    sample_valid_d    = tag_vld_q[LAT-1];
    sample_d          = '0;
    sample_freqaddr_d = '0;
    sample_phase_d    = '0;
    sample_first_d    = 1'b0;
    sample_last_d     = 1'b0;
    if (tag_vld_q[LAT-1]) begin
      sample_d          = scale_sample(env_rdata, tag_q[LAT-1].amp);
      sample_freqaddr_d = tag_q[LAT-1].freq;
      sample_phase_d    = tag_q[LAT-1].phase;
      sample_first_d    = tag_q[LAT-1].first;
      sample_last_d     = tag_q[LAT-1].last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      pend_vld_q        <= 1'b0;
      overrun_q         <= 1'b0;
      tag_vld_q         <= '0;
      sample_valid_q    <= 1'b0;
      sample_q          <= '0;
      sample_freqaddr_q <= '0;
      sample_phase_q    <= '0;
      sample_first_q    <= 1'b0;
      sample_last_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      pend_vld_q        <= pend_vld_d;
      overrun_q         <= overrun_d;
      tag_vld_q         <= tag_vld_d;
      sample_valid_q    <= sample_valid_d;
      sample_q          <= sample_d;
      sample_freqaddr_q <= sample_freqaddr_d;
      sample_phase_q    <= sample_phase_d;
      sample_first_q    <= sample_first_d;
      sample_last_q     <= sample_last_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q  <= cur_d;
    pend_q <= pend_d;
    tag_q  <= tag_d;
  end

  assign busy            = (state_q != IDLE) || (tag_vld_q != '0) || sample_valid_q;
  assign sample_valid    = sample_valid_q;
  assign sample          = sample_q;
  assign sample_freqaddr = sample_freqaddr_q;
  assign sample_phase    = sample_phase_q;
  assign sample_first    = sample_first_q;
  assign sample_last     = sample_last_q;
  assign overrun         = overrun_q;

endmodule
